// File: rtl/aftab_trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses touched during
// trap entry, xRET and mip refresh, the privilege encodings, the sequencer
// state encoding and a small helper that picks the machine or user address.
package aftab_trap_sequencer_pkg;

   // Machine-level CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   // User-level CSR addresses
   localparam logic [11:0] CSR_USTATUS = 12'h000;
   localparam logic [11:0] CSR_UTVEC   = 12'h005;
   localparam logic [11:0] CSR_UEPC    = 12'h041;
   localparam logic [11:0] CSR_UCAUSE  = 12'h042;
   localparam logic [11:0] CSR_UTVAL   = 12'h043;

   // Privilege levels driven on newPRV
   localparam logic [1:0] PRV_USER    = 2'b00;
   localparam logic [1:0] PRV_MACHINE = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_T_STATUS = 4'd1,
      ST_T_EPC    = 4'd2,
      ST_T_CAUSE  = 4'd3,
      ST_T_TVAL   = 4'd4,
      ST_T_VEC    = 4'd5,
      ST_R_STATUS = 4'd6,
      ST_R_EPC    = 4'd7,
      ST_MIP      = 4'd8
   } seqState_e;

   // User-level CSRs mirror the machine ones, so every step just chooses
   // between a machine and a user address.
   function automatic logic [11:0] pickAddr(input logic toUser,
                                            input logic [11:0] machineAddr,
                                            input logic [11:0] userAddr);
      return toUser ? userAddr : machineAddr;
   endfunction

endpackage

// File: rtl/aftab_trap_sequencer.sv
// Trap / xRET / mip-refresh sequencer. Walks the CSR datapath through the
// writes needed for trap entry and return, one CSR per cycle, then loads the
// new PC and privilege level on the final cycle. Outputs are Moore-decoded
// from the state and the level bits latched when the request was accepted.
module aftab_trap_sequencer
   import aftab_trap_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        trapReq,
   input  logic        trapToUser,
   input  logic        retReq,
   input  logic        retIsMret,
   input  logic        mipUpdateReq,
   input  logic [1:0]  previousPRV,
   output logic        selPC,
   output logic        selCause,
   output logic        selTval,
   output logic        selmip,
   output logic        machineStatusAlterationPreCSR,
   output logic        userStatusAlterationPreCSR,
   output logic        machineStatusAlterationPostCSR,
   output logic        userStatusAlterationPostCSR,
   output logic [11:0] csrAddr,
   output logic        writeCSR,
   output logic        ldPCfromCSR,
   output logic        ldPRV,
   output logic [1:0]  newPRV,
   output logic        busy,
   output logic        done
);

   seqState_e state_q, state_d;
   logic      toUser_q, toUser_d;
   logic      isMret_q, isMret_d;

   // State register plus the level bits; reset abandons any sequence in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         toUser_q <= 1'b0;
         isMret_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         toUser_q <= toUser_d;
         isMret_q <= isMret_d;
      end
   end

   // Next state: requests are only looked at in IDLE, trap beats ret beats mip,
   // and the level bit of the winning request is captured on acceptance
   always_comb begin
      state_d  = state_q;
      toUser_d = toUser_q;
      isMret_d = isMret_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trapReq) begin
               state_d  = ST_T_STATUS;
               toUser_d = trapToUser;
            end else if (retReq) begin
               state_d  = ST_R_STATUS;
               isMret_d = retIsMret;
            end else if (mipUpdateReq) begin
               state_d  = ST_MIP;
            end
         end
         ST_T_STATUS: state_d = ST_T_EPC;
         ST_T_EPC:    state_d = ST_T_CAUSE;
         ST_T_CAUSE:  state_d = ST_T_TVAL;
         ST_T_TVAL:   state_d = ST_T_VEC;
         ST_T_VEC:    state_d = ST_IDLE;
         ST_R_STATUS: state_d = ST_R_EPC;
         ST_R_EPC:    state_d = ST_IDLE;
         ST_MIP:      state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output decode: one CSR address per state, a single select line at most,
   // and the write enable never overlapping the PC load
   always_comb begin
      selPC                          = 1'b0;
      selCause                       = 1'b0;
      selTval                        = 1'b0;
      selmip                         = 1'b0;
      machineStatusAlterationPreCSR  = 1'b0;
      userStatusAlterationPreCSR     = 1'b0;
      machineStatusAlterationPostCSR = 1'b0;
      userStatusAlterationPostCSR    = 1'b0;
      csrAddr                        = 12'h000;
      writeCSR                       = 1'b0;
      ldPCfromCSR                    = 1'b0;
      ldPRV                          = 1'b0;
      newPRV                         = 2'b00;
      done                           = 1'b0;
      busy                           = (state_q != ST_IDLE);
      unique case (state_q)
         ST_T_STATUS: begin
            machineStatusAlterationPreCSR = ~toUser_q;
            userStatusAlterationPreCSR    = toUser_q;
            csrAddr  = pickAddr(toUser_q, CSR_MSTATUS, CSR_USTATUS);
            writeCSR = 1'b1;
         end
         ST_T_EPC: begin
            selPC    = 1'b1;
            csrAddr  = pickAddr(toUser_q, CSR_MEPC, CSR_UEPC);
            writeCSR = 1'b1;
         end
         ST_T_CAUSE: begin
            selCause = 1'b1;
            csrAddr  = pickAddr(toUser_q, CSR_MCAUSE, CSR_UCAUSE);
            writeCSR = 1'b1;
         end
         ST_T_TVAL: begin
            selTval  = 1'b1;
            csrAddr  = pickAddr(toUser_q, CSR_MTVAL, CSR_UTVAL);
            writeCSR = 1'b1;
         end
         ST_T_VEC: begin
            csrAddr     = pickAddr(toUser_q, CSR_MTVEC, CSR_UTVEC);
            ldPCfromCSR = 1'b1;
            ldPRV       = 1'b1;
            newPRV      = toUser_q ? PRV_USER : PRV_MACHINE;
            done        = 1'b1;
         end
         ST_R_STATUS: begin
            machineStatusAlterationPostCSR = isMret_q;
            userStatusAlterationPostCSR    = ~isMret_q;
            csrAddr  = pickAddr(~isMret_q, CSR_MSTATUS, CSR_USTATUS);
            writeCSR = 1'b1;
         end
         ST_R_EPC: begin
            csrAddr     = pickAddr(~isMret_q, CSR_MEPC, CSR_UEPC);
            ldPCfromCSR = 1'b1;
            ldPRV       = 1'b1;
            newPRV      = isMret_q ? previousPRV : PRV_USER;
            done        = 1'b1;
         end
         ST_MIP: begin
            selmip   = 1'b1;
            csrAddr  = CSR_MIP;
            writeCSR = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_aftab_trap_sequencer.sv
// Directed bench for the trap sequencer: machine/user trap, mret/uret,
// request priority, mip refresh and asynchronous reset mid-sequence.
module tb_aftab_trap_sequencer;

   logic        clk;
   logic        rst;
   logic        trapReq;
   logic        trapToUser;
   logic        retReq;
   logic        retIsMret;
   logic        mipUpdateReq;
   logic [1:0]  previousPRV;
   logic        selPC;
   logic        selCause;
   logic        selTval;
   logic        selmip;
   logic        mPre;
   logic        uPre;
   logic        mPost;
   logic        uPost;
   logic [11:0] csrAddr;
   logic        writeCSR;
   logic        ldPCfromCSR;
   logic        ldPRV;
   logic [1:0]  newPRV;
   logic        busy;
   logic        done;

   int testCount;
   int failCount;

   aftab_trap_sequencer dut (
      .clk                            (clk),
      .rst                            (rst),
      .trapReq                        (trapReq),
      .trapToUser                     (trapToUser),
      .retReq                         (retReq),
      .retIsMret                      (retIsMret),
      .mipUpdateReq                   (mipUpdateReq),
      .previousPRV                    (previousPRV),
      .selPC                          (selPC),
      .selCause                       (selCause),
      .selTval                        (selTval),
      .selmip                         (selmip),
      .machineStatusAlterationPreCSR  (mPre),
      .userStatusAlterationPreCSR     (uPre),
      .machineStatusAlterationPostCSR (mPost),
      .userStatusAlterationPostCSR    (uPost),
      .csrAddr                        (csrAddr),
      .writeCSR                       (writeCSR),
      .ldPCfromCSR                    (ldPCfromCSR),
      .ldPRV                          (ldPRV),
      .newPRV                         (newPRV),
      .busy                           (busy),
      .done                           (done)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the test and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive request inputs, then advance to just after the next rising edge
   task automatic applyStimulus(input logic trap, input logic toUser,
                                input logic ret, input logic mret,
                                input logic mip, input logic [1:0] prv);
      trapReq      = trap;
      trapToUser   = toUser;
      retReq       = ret;
      retIsMret    = mret;
      mipUpdateReq = mip;
      previousPRV  = prv;
      @(posedge clk);
      #1;
   endtask

   // Compare the full output vector against a hand-written expectation,
   // plus the one-hot select and write/PC-load exclusivity properties
   task automatic checkCycle(input string tag, input logic [3:0] sels,
                             input logic [3:0] stat, input logic [11:0] addr,
                             input logic wr, input logic ldpc, input logic ldprv,
                             input logic [1:0] prv, input logic bsy,
                             input logic dn);
      logic [26:0] obs;
      logic [26:0] expv;
      obs  = {selPC, selCause, selTval, selmip, mPre, uPre, mPost, uPost,
              csrAddr, writeCSR, ldPCfromCSR, ldPRV, newPRV, busy, done};
      expv = {sels, stat, addr, wr, ldpc, ldprv, prv, bsy, dn};
      checkOutput(tag, {5'b0, obs}, {5'b0, expv});
      checkOutput({tag, "_onehot"},
                  {31'b0, $onehot0({selPC, selCause, selTval, selmip})}, 32'd1);
      checkOutput({tag, "_wrExcl"}, {31'b0, writeCSR & ldPCfromCSR}, 32'd0);
   endtask

   initial begin
      testCount    = 0;
      failCount    = 0;
      rst          = 1'b0;
      trapReq      = 1'b0;
      trapToUser   = 1'b0;
      retReq       = 1'b0;
      retIsMret    = 1'b0;
      mipUpdateReq = 1'b0;
      previousPRV  = 2'b00;

      #2;
      checkCycle("reset", 4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("idle", 4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // Machine trap
      applyStimulus(1, 0, 0, 0, 0, 2'b00);
      checkCycle("mt_status", 4'b0000, 4'b1000, 12'h300, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("mt_epc",    4'b1000, 4'b0000, 12'h341, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 2'b00);
      checkCycle("mt_cause",  4'b0100, 4'b0000, 12'h342, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("mt_tval",   4'b0010, 4'b0000, 12'h343, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("mt_vec",    4'b0000, 4'b0000, 12'h305, 0, 1, 1, 2'b11, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("mt_idle",   4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // User trap
      applyStimulus(1, 1, 0, 0, 0, 2'b00);
      checkCycle("ut_status", 4'b0000, 4'b0100, 12'h000, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("ut_epc",    4'b1000, 4'b0000, 12'h041, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("ut_cause",  4'b0100, 4'b0000, 12'h042, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("ut_tval",   4'b0010, 4'b0000, 12'h043, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b11);
      checkCycle("ut_vec",    4'b0000, 4'b0000, 12'h005, 0, 1, 1, 2'b00, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("ut_idle",   4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // mret back to supervisor-encoded level 01
      applyStimulus(0, 0, 1, 1, 0, 2'b01);
      checkCycle("mret_status", 4'b0000, 4'b0010, 12'h300, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b01);
      checkCycle("mret_epc",    4'b0000, 4'b0000, 12'h341, 0, 1, 1, 2'b01, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 2'b01);
      checkCycle("mret_idle",   4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // uret ignores previousPRV
      applyStimulus(0, 0, 1, 0, 0, 2'b11);
      checkCycle("uret_status", 4'b0000, 4'b0001, 12'h000, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 1, 0, 2'b11);
      checkCycle("uret_epc",    4'b0000, 4'b0000, 12'h041, 0, 1, 1, 2'b00, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("uret_idle",   4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // All three requests at once: trap wins, retReq held mid-sequence is ignored
      applyStimulus(1, 0, 1, 1, 1, 2'b00);
      checkCycle("pri_status", 4'b0000, 4'b1000, 12'h300, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 2'b00);
      checkCycle("pri_epc",    4'b1000, 4'b0000, 12'h341, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 2'b00);
      checkCycle("pri_cause",  4'b0100, 4'b0000, 12'h342, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 2'b00);
      checkCycle("pri_tval",   4'b0010, 4'b0000, 12'h343, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 2'b00);
      checkCycle("pri_vec",    4'b0000, 4'b0000, 12'h305, 0, 1, 1, 2'b11, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("pri_idle",   4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // mip refresh after busy falls
      applyStimulus(0, 0, 0, 0, 1, 2'b00);
      checkCycle("mip",      4'b0001, 4'b0000, 12'h344, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("mip_idle", 4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);

      // Asynchronous reset during T_CAUSE of a user trap
      applyStimulus(1, 1, 0, 0, 0, 2'b00);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("rst_cause", 4'b0100, 4'b0000, 12'h042, 1, 0, 0, 2'b00, 1, 0);
      #1;
      rst = 1'b0;
      #1;
      checkCycle("rst_async", 4'b0, 4'b0, 12'h000, 0, 0, 0, 2'b00, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 2'b00);
      checkCycle("rst_restart", 4'b0000, 4'b1000, 12'h300, 1, 0, 0, 2'b00, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 2'b00);
      checkCycle("rst_restart_epc", 4'b1000, 4'b0000, 12'h341, 1, 0, 0, 2'b00, 1, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
